// File: rtl/nexys_starship_pkg.sv
// rtl/nexys_starship_pkg.sv - shared state encodings, LFSR mask and parameter defaults
// Purpose: common definitions for the starship monster controllers (top/bottom/left/right).
// Contents: parameter defaults, 16-bit Galois LFSR mask and seed, one-hot controller state type.
package nexys_starship_pkg;

   localparam int          SPAWN_MIN_DEFAULT    = 8;
   localparam int          ATTACK_TICKS_DEFAULT = 40;
   localparam int          RAND_EN_DEFAULT      = 1;
   localparam logic [15:0] LFSR_SEED_DEFAULT    = 16'hACE1;
   localparam logic [15:0] LFSR_MASK            = 16'hB400;

   // One-hot encoding: each state bit doubles as its q_TMC_* status flag.
   typedef enum logic [3:0] {
      TMC_IDLE   = 4'b0001,
      TMC_WAIT   = 4'b0010,
      TMC_ACTIVE = 4'b0100,
      TMC_BROKEN = 4'b1000
   } tmc_state_t;

endpackage

// File: rtl/nexys_starship_tmc_if.sv
// rtl/nexys_starship_tmc_if.sv - game-side signal bundle of a monster controller
// Purpose: groups the game inputs and monster status outputs of one station.
// master: drives play_flag, tick, shoot_top; observes the status outputs.
// slave : the controller; drives top_monster_ctrl, top_broken, kill_pulse, top_timer.
interface nexys_starship_tmc_if;

   logic       play_flag;
   logic       tick;
   logic       shoot_top;
   logic       top_monster_ctrl;
   logic       top_broken;
   logic       kill_pulse;
   logic [7:0] top_timer;

   modport master (
      output play_flag, tick, shoot_top,
      input  top_monster_ctrl, top_broken, kill_pulse, top_timer
   );

   modport slave (
      input  play_flag, tick, shoot_top,
      output top_monster_ctrl, top_broken, kill_pulse, top_timer
   );

endinterface

// File: rtl/nexys_starship_lfsr16.sv
// rtl/nexys_starship_lfsr16.sv - free-running 16-bit Galois LFSR
// Purpose: pseudo-random source shared by all monster controllers.
// Ports: Clk (in), Reset (in, async active-high), rnd (out, OUT_W low bits of the LFSR).
module nexys_starship_lfsr16
   import nexys_starship_pkg::*;
#(
   parameter logic [15:0] SEED  = LFSR_SEED_DEFAULT,
   parameter logic [15:0] MASK  = LFSR_MASK,
   parameter int          OUT_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   output logic [OUT_W-1:0] rnd
);

   logic [15:0] lfsr_q;

   // Galois form: shift right, fold the mask in when the bit shifted out is 1.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lfsr_q <= SEED;
      end else if (lfsr_q[0]) begin
         lfsr_q <= (lfsr_q >> 1) ^ MASK;
      end else begin
         lfsr_q <= lfsr_q >> 1;
      end
   end

   assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/nexys_starship_tmc.sv
// rtl/nexys_starship_tmc.sv - top-station monster controller (spawn, attack, kill, hull breach)
// Purpose: spawns a monster after a (randomised) delay, lets it attack for ATTACK_TICKS
//          ticks, and either reports a kill on shoot_top or latches a hull breach.
// Ports: Clk (in), Reset (in, async active-high), bus (slave modport: play_flag, tick,
//        shoot_top in; top_monster_ctrl, top_broken, kill_pulse, top_timer out),
//        q_TMC_Idle/Wait/Active/Broken (out, one-hot state flags).
module nexys_starship_tmc
   import nexys_starship_pkg::*;
#(
   parameter int          SPAWN_MIN    = SPAWN_MIN_DEFAULT,
   parameter int          ATTACK_TICKS = ATTACK_TICKS_DEFAULT,
   parameter int          RAND_EN      = RAND_EN_DEFAULT,
   parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
   input  logic                        Clk,
   input  logic                        Reset,
   nexys_starship_tmc_if.slave         bus,
   output logic                        q_TMC_Idle,
   output logic                        q_TMC_Wait,
   output logic                        q_TMC_Active,
   output logic                        q_TMC_Broken
);

   tmc_state_t state;
   logic [7:0] timer;
   logic       monster_ctrl;
   logic       broken;
   logic       kill;
   logic [3:0] rnd;
   logic [7:0] spawn_delay;

   nexys_starship_lfsr16 #(
      .SEED  (LFSR_SEED),
      .MASK  (LFSR_MASK),
      .OUT_W (4)
   ) u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .rnd   (rnd)
   );

   // Uses the LFSR value present in the cycle the load happens.
   assign spawn_delay = 8'(SPAWN_MIN) + ((RAND_EN != 0) ? {4'd0, rnd} : 8'd0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= TMC_IDLE;
         timer        <= 8'd0;
         monster_ctrl <= 1'b0;
         broken       <= 1'b0;
         kill         <= 1'b0;
      end else begin
         kill <= 1'b0;
         // Leaving the game beats every other event, including a same-cycle shot.
         if (!bus.play_flag) begin
            state        <= TMC_IDLE;
            timer        <= 8'd0;
            monster_ctrl <= 1'b0;
            broken       <= 1'b0;
         end else begin
            case (state)
               TMC_IDLE: begin
                  state <= TMC_WAIT;
                  timer <= spawn_delay;
               end
               TMC_WAIT: begin
                  if (bus.tick) begin
                     if (timer <= 8'd1) begin
                        state        <= TMC_ACTIVE;
                        timer        <= 8'(ATTACK_TICKS);
                        monster_ctrl <= 1'b1;
                     end else begin
                        timer <= timer - 8'd1;
                     end
                  end
               end
               TMC_ACTIVE: begin
                  // A shot in the same cycle as the final tick still counts as a kill.
                  if (bus.shoot_top) begin
                     kill         <= 1'b1;
                     monster_ctrl <= 1'b0;
                     state        <= TMC_WAIT;
                     timer        <= spawn_delay;
                  end else if (bus.tick) begin
                     if (timer <= 8'd1) begin
                        state        <= TMC_BROKEN;
                        broken       <= 1'b1;
                        monster_ctrl <= 1'b1;
                        timer        <= 8'd0;
                     end else begin
                        timer <= timer - 8'd1;
                     end
                  end
               end
               TMC_BROKEN: begin
                  broken       <= 1'b1;
                  monster_ctrl <= 1'b1;
                  timer        <= 8'd0;
               end
               default: begin
                  state        <= TMC_IDLE;
                  timer        <= 8'd0;
                  monster_ctrl <= 1'b0;
                  broken       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.top_monster_ctrl = monster_ctrl;
   assign bus.top_broken       = broken;
   assign bus.kill_pulse       = kill;
   assign bus.top_timer        = timer;

   assign q_TMC_Idle   = state[0];
   assign q_TMC_Wait   = state[1];
   assign q_TMC_Active = state[2];
   assign q_TMC_Broken = state[3];

endmodule

// File: tb/tb_nexys_starship_tmc.sv
// tb/tb_nexys_starship_tmc.sv - directed self-checking bench for nexys_starship_tmc
// Purpose: three controller instances (fixed spawn, short attack, randomised spawn)
//          driven with directed vectors and compared against hand-computed values.
module tb_nexys_starship_tmc;

   logic Clk;
   logic Reset;
   int   n_checks;
   int   n_fail;

   nexys_starship_tmc_if ifa ();
   nexys_starship_tmc_if ifb ();
   nexys_starship_tmc_if ifc ();

   logic a_idle, a_wait, a_active, a_broken;
   logic b_idle, b_wait, b_active, b_broken;
   logic c_idle, c_wait, c_active, c_broken;

   nexys_starship_tmc #(.SPAWN_MIN(4), .ATTACK_TICKS(40), .RAND_EN(0)) dut_a (
      .Clk(Clk), .Reset(Reset), .bus(ifa.slave),
      .q_TMC_Idle(a_idle), .q_TMC_Wait(a_wait), .q_TMC_Active(a_active), .q_TMC_Broken(a_broken)
   );

   nexys_starship_tmc #(.SPAWN_MIN(4), .ATTACK_TICKS(3), .RAND_EN(0)) dut_b (
      .Clk(Clk), .Reset(Reset), .bus(ifb.slave),
      .q_TMC_Idle(b_idle), .q_TMC_Wait(b_wait), .q_TMC_Active(b_active), .q_TMC_Broken(b_broken)
   );

   nexys_starship_tmc dut_c (
      .Clk(Clk), .Reset(Reset), .bus(ifc.slave),
      .q_TMC_Idle(c_idle), .q_TMC_Wait(c_wait), .q_TMC_Active(c_active), .q_TMC_Broken(c_broken)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic a_ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat (gap) step();
         ifa.tick = 1'b1;
         step();
         ifa.tick = 1'b0;
      end
   endtask

   task automatic b_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         ifb.tick = 1'b1;
         step();
         ifb.tick = 1'b0;
      end
   endtask

   initial begin
      int          d;
      int          bad;
      int          distinct;
      logic [31:0] seen;

      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b1;
      {ifa.play_flag, ifa.tick, ifa.shoot_top} = 3'b000;
      {ifb.play_flag, ifb.tick, ifb.shoot_top} = 3'b000;
      {ifc.play_flag, ifc.tick, ifc.shoot_top} = 3'b000;

      // Reset state
      #12;
      check("rst_flags", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h1);
      check("rst_outs", {29'd0, ifa.top_monster_ctrl, ifa.top_broken, ifa.kill_pulse}, 32'h0);
      check("rst_timer", {24'd0, ifa.top_timer}, 32'h0);
      check("rst_lfsr", {16'd0, dut_a.u_lfsr.lfsr_q}, 32'hACE1);
      Reset = 1'b0;
      step();
      check("lfsr_step1", {16'd0, dut_a.u_lfsr.lfsr_q}, 32'hE270);
      step();
      check("lfsr_step2", {16'd0, dut_a.u_lfsr.lfsr_q}, 32'h7138);

      // Spawn timing, fixed delay 4, tick every 10 Clk
      ifa.play_flag = 1'b1;
      step();
      check("spawn_wait", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h2);
      check("spawn_load", {24'd0, ifa.top_timer}, 32'd4);
      a_ticks(3, 9);
      check("spawn_t3_ctrl", {31'd0, ifa.top_monster_ctrl}, 32'd0);
      check("spawn_t3_timer", {24'd0, ifa.top_timer}, 32'd1);
      a_ticks(1, 9);
      check("spawn_t4_ctrl", {31'd0, ifa.top_monster_ctrl}, 32'd1);
      check("spawn_t4_timer", {24'd0, ifa.top_timer}, 32'd40);
      check("spawn_t4_state", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h4);

      // Kill at timer 17
      a_ticks(23, 1);
      check("kill_pre_timer", {24'd0, ifa.top_timer}, 32'd17);
      ifa.shoot_top = 1'b1;
      step();
      ifa.shoot_top = 1'b0;
      check("kill_pulse", {31'd0, ifa.kill_pulse}, 32'd1);
      check("kill_ctrl", {31'd0, ifa.top_monster_ctrl}, 32'd0);
      check("kill_state", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h2);
      check("kill_timer", {24'd0, ifa.top_timer}, 32'd4);
      step();
      check("kill_one_cycle", {31'd0, ifa.kill_pulse}, 32'd0);

      // Shot in WAIT is ignored
      ifa.shoot_top = 1'b1;
      step();
      ifa.shoot_top = 1'b0;
      check("wait_shoot_kill", {31'd0, ifa.kill_pulse}, 32'd0);
      check("wait_shoot_timer", {24'd0, ifa.top_timer}, 32'd4);

      // Shot and tick together at timer 1 -> kill
      a_ticks(4, 1);
      a_ticks(39, 1);
      check("sim_pre_timer", {24'd0, ifa.top_timer}, 32'd1);
      ifa.shoot_top = 1'b1;
      ifa.tick      = 1'b1;
      step();
      {ifa.shoot_top, ifa.tick} = 2'b00;
      check("sim_kill", {31'd0, ifa.kill_pulse}, 32'd1);
      check("sim_state", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h2);
      check("sim_broken", {31'd0, ifa.top_broken}, 32'd0);

      // play_flag=0 with shot and tick -> IDLE without kill
      a_ticks(4, 1);
      check("stop_pre_state", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h4);
      ifa.play_flag = 1'b0;
      ifa.shoot_top = 1'b1;
      ifa.tick      = 1'b1;
      step();
      {ifa.shoot_top, ifa.tick} = 2'b00;
      check("stop_state", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h1);
      check("stop_outs", {29'd0, ifa.top_monster_ctrl, ifa.top_broken, ifa.kill_pulse}, 32'h0);
      check("stop_timer", {24'd0, ifa.top_timer}, 32'd0);

      // Asynchronous reset mid-ACTIVE
      ifa.play_flag = 1'b1;
      step();
      a_ticks(4, 1);
      check("arst_pre_ctrl", {31'd0, ifa.top_monster_ctrl}, 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      check("arst_ctrl", {31'd0, ifa.top_monster_ctrl}, 32'd0);
      check("arst_flags", {28'd0, a_broken, a_active, a_wait, a_idle}, 32'h1);
      check("arst_timer", {24'd0, ifa.top_timer}, 32'd0);
      ifa.play_flag = 1'b0;
      #3;
      Reset = 1'b0;
      #1;
      check("arst_rel_idle", {31'd0, a_idle}, 32'd1);
      check("arst_rel_lfsr", {16'd0, dut_a.u_lfsr.lfsr_q}, 32'hACE1);
      step();

      // Hull breach with ATTACK_TICKS=3
      ifb.play_flag = 1'b1;
      step();
      b_ticks(4);
      check("hull_active", {24'd0, ifb.top_timer}, 32'd3);
      b_ticks(2);
      check("hull_t2_broken", {31'd0, ifb.top_broken}, 32'd0);
      b_ticks(1);
      check("hull_t3_broken", {31'd0, ifb.top_broken}, 32'd1);
      check("hull_t3_ctrl", {31'd0, ifb.top_monster_ctrl}, 32'd1);
      check("hull_t3_state", {28'd0, b_broken, b_active, b_wait, b_idle}, 32'h8);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         ifb.tick      = 1'b1;
         ifb.shoot_top = i[0];
         step();
         if (!(ifb.top_broken && ifb.top_monster_ctrl && ifb.top_timer == 8'd0 &&
               !ifb.kill_pulse && b_broken))
            bad++;
      end
      {ifb.tick, ifb.shoot_top} = 2'b00;
      check("hull_hold", bad, 32'd0);
      ifb.play_flag = 1'b0;
      step();
      check("hull_exit", {28'd0, b_broken, b_active, b_wait, b_idle, ifb.top_broken}, 32'h2);

      // Randomised spawn delays, 200 spawns
      seen = 32'd0;
      ifc.play_flag = 1'b1;
      step();
      for (int s = 0; s < 200; s++) begin
         d = 0;
         ifc.tick = 1'b1;
         while (d <= 40) begin
            step();
            d++;
            if (ifc.top_monster_ctrl) break;
         end
         ifc.tick = 1'b0;
         check("spawn_range", {31'd0, (d >= 8 && d <= 23)}, 32'd1);
         if (d < 32) seen[d] = 1'b1;
         ifc.shoot_top = 1'b1;
         step();
         ifc.shoot_top = 1'b0;
      end
      distinct = $countones(seen);
      check("spawn_distinct", {31'd0, distinct >= 12}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
